// File: rtl/i_merge4.sv
// rtl/i_merge4.sv - 4:1 packet merge with whole-packet arbitration and source route tagging
//
// Purpose:
//   Merges four packet streams onto one output. A packet (header through TLAST
//   beat) is never interleaved with another. On a header beat the 2-bit source
//   port is pushed into route bits [55:48] so a steer on the return path can send
//   the reply back to the same port. A 2-entry buffer sits between the arbiter
//   and the output.
//
// Parameters:
//   ADD_ROUTE  1 = tag header route field with the source port, 0 = pass through
//
// Macro:
//   I_MERGE4_FIXED_PRIORITY_EN  defined: lowest-numbered valid port wins when
//                               unlocked; undefined: round-robin from rr_next
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   In_TVALID/TREADY/TDATA/TLAST input packet ports n = 0..3
//   O_TVALID/TREADY/TDATA/TLAST  merged output port

module i_merge4 #(
    parameter int ADD_ROUTE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        I0_TVALID,
    output logic        I0_TREADY,
    input  logic [63:0] I0_TDATA,
    input  logic        I0_TLAST,
    input  logic        I1_TVALID,
    output logic        I1_TREADY,
    input  logic [63:0] I1_TDATA,
    input  logic        I1_TLAST,
    input  logic        I2_TVALID,
    output logic        I2_TREADY,
    input  logic [63:0] I2_TDATA,
    input  logic        I2_TLAST,
    input  logic        I3_TVALID,
    output logic        I3_TREADY,
    input  logic [63:0] I3_TDATA,
    input  logic        I3_TLAST,
    output logic        O_TVALID,
    input  logic        O_TREADY,
    output logic [63:0] O_TDATA,
    output logic        O_TLAST
);

    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [63:0] in_data [4];

    assign in_valid   = {I3_TVALID, I2_TVALID, I1_TVALID, I0_TVALID};
    assign in_last    = {I3_TLAST, I2_TLAST, I1_TLAST, I0_TLAST};
    assign in_data[0] = I0_TDATA;
    assign in_data[1] = I1_TDATA;
    assign in_data[2] = I2_TDATA;
    assign in_data[3] = I3_TDATA;

    // Arbiter state
    logic        locked_q, locked_d;
    logic [1:0]  held_port_q, held_port_d;
`ifndef I_MERGE4_FIXED_PRIORITY_EN
    logic [1:0]  rr_next_q, rr_next_d;
`endif

    // 2-entry buffer of {TLAST, TDATA}
    logic [64:0] mem_q [2];
    logic [64:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic [1:0]  sel;
    logic        s_ready;
    logic [3:0]  tready;
    logic        accept;
    logic        pop;
    logic [63:0] sel_data;
    logic        sel_last;
    logic [63:0] out_data;

    // Port selection is purely combinational so a waiting header is taken in
    // the same cycle it is seen; no arbitration bubble.
    always_comb begin
        sel = 2'd0;
        if (locked_q) begin
            sel = held_port_q;
        end else begin
`ifdef I_MERGE4_FIXED_PRIORITY_EN
            // Descending scan so the lowest valid port is the last to assign.
            for (int k = 3; k >= 0; k--) begin
                if (in_valid[k]) begin
                    sel = 2'(k);
                end
            end
`else
            // Descending offset scan so the nearest port after rr_next wins.
            sel = rr_next_q;
            for (int k = 3; k >= 0; k--) begin
                if (in_valid[rr_next_q + 2'(k)]) begin
                    sel = rr_next_q + 2'(k);
                end
            end
`endif
        end
    end

    assign s_ready = !reset && (count_q != 2'd2);

    always_comb begin
        tready = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            tready[n] = s_ready && (sel == 2'(n)) && (locked_q || in_valid[n]);
        end
    end

    assign accept   = |(tready & in_valid);
    assign sel_data = in_data[sel];
    assign sel_last = in_last[sel];
    assign pop      = (count_q != 2'd0) && O_TREADY;

    // Any beat accepted while unlocked is a header. Route bits [55:54] fall off
    // the top, which limits the merge tree depth to four levels.
    always_comb begin
        out_data = sel_data;
        if ((ADD_ROUTE != 0) && !locked_q) begin
            out_data = {sel_data[63:56], sel_data[53:48], sel, sel_data[47:0]};
        end
    end

    always_comb begin
        locked_d    = locked_q;
        held_port_d = held_port_q;
`ifndef I_MERGE4_FIXED_PRIORITY_EN
        rr_next_d   = rr_next_q;
`endif
        if (accept) begin
            if (sel_last) begin
                locked_d  = 1'b0;
`ifndef I_MERGE4_FIXED_PRIORITY_EN
                rr_next_d = sel + 2'd1;
`endif
            end else if (!locked_q) begin
                locked_d    = 1'b1;
                held_port_d = sel;
            end
        end
    end

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            mem_d[wr_ptr_q] = {sel_last, out_data};
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + {1'b0, accept} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q    <= 1'b0;
            held_port_q <= 2'd0;
`ifndef I_MERGE4_FIXED_PRIORITY_EN
            rr_next_q   <= 2'd0;
`endif
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            locked_q    <= locked_d;
            held_port_q <= held_port_d;
`ifndef I_MERGE4_FIXED_PRIORITY_EN
            rr_next_q   <= rr_next_d;
`endif
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign O_TVALID           = (count_q != 2'd0);
    assign {O_TLAST, O_TDATA} = mem_q[rd_ptr_q];

    assign I0_TREADY = tready[0];
    assign I1_TREADY = tready[1];
    assign I2_TREADY = tready[2];
    assign I3_TREADY = tready[3];

endmodule

// File: tb/tb_i_merge4.sv
// tb/tb_i_merge4.sv - self-checking bench for i_merge4 against a packet-level model

module tb_i_merge4;

    localparam int ADD_ROUTE = 1;

    logic        clk;
    logic        reset;
    logic [3:0]  i_tvalid;
    logic [3:0]  i_tready;
    logic [3:0]  i_tlast;
    logic [63:0] i_tdata [4];
    logic        o_tvalid;
    logic        o_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;

    i_merge4 #(.ADD_ROUTE(ADD_ROUTE)) dut (
        .clk(clk), .reset(reset),
        .I0_TVALID(i_tvalid[0]), .I0_TREADY(i_tready[0]), .I0_TDATA(i_tdata[0]), .I0_TLAST(i_tlast[0]),
        .I1_TVALID(i_tvalid[1]), .I1_TREADY(i_tready[1]), .I1_TDATA(i_tdata[1]), .I1_TLAST(i_tlast[1]),
        .I2_TVALID(i_tvalid[2]), .I2_TREADY(i_tready[2]), .I2_TDATA(i_tdata[2]), .I2_TLAST(i_tlast[2]),
        .I3_TVALID(i_tvalid[3]), .I3_TREADY(i_tready[3]), .I3_TDATA(i_tdata[3]), .I3_TLAST(i_tlast[3]),
        .O_TVALID(o_tvalid), .O_TREADY(o_tready), .O_TDATA(o_tdata), .O_TLAST(o_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-port beat queues {last, data}, idle cycles before each beat
    logic [64:0] src_q [4][$];
    int          gap_q [4][$];
    logic [64:0] exp_q [$];
    logic [64:0] got_q [$];
    logic        ordy_pat [$];
    logic        ov_trace [$];
    logic [3:0]  rdy_trace [$];
    int          out_cyc [$];
    int          bp_pct;
    int          model_rr;
    int          compared;
    int          mismatched;
    int          first_acc_cyc, first_out_cyc, max_occ, hold_err, multi_rdy_err;
    logic [3:0]  rst_rdy;
    logic        rst_ov;

    function automatic logic [64:0] xform(logic [64:0] beat, int port, bit hdr);
        logic [64:0] o;
        logic [7:0]  r;
        o = beat;
        if (hdr && ADD_ROUTE != 0) begin
            r = beat[55:48];
            r = (r << 2) | 8'(port);
            o[55:48] = r;
        end
        return o;
    endfunction

    // Packet-level model: whole packets in arbitration order, assuming every
    // port with pending work presents its header whenever the merge is idle.
    task automatic build_expected();
        logic [64:0] q [4][$];
        int p;
        bit hdr;
        logic [64:0] b;
        for (int i = 0; i < 4; i++) q[i] = src_q[i];
        forever begin
            p = -1;
`ifdef I_MERGE4_FIXED_PRIORITY_EN
            for (int i = 3; i >= 0; i--) if (q[i].size() > 0) p = i;
`else
            for (int i = 0; i < 4; i++)
                if (p < 0 && q[(model_rr + i) % 4].size() > 0) p = (model_rr + i) % 4;
`endif
            if (p < 0) break;
            hdr = 1'b1;
            do begin
                b = q[p].pop_front();
                exp_q.push_back(xform(b, p, hdr));
                hdr = 1'b0;
            end while (!b[64] && q[p].size() > 0);
            model_rr = (p + 1) % 4;
        end
    endtask

    task automatic clear_all();
        for (int p = 0; p < 4; p++) begin
            src_q[p].delete();
            gap_q[p].delete();
        end
        exp_q.delete();
        got_q.delete();
        ordy_pat.delete();
    endtask

    task automatic add_pkt(int port, int len, int gap_max, logic [7:0] route);
        logic [63:0] d;
        for (int b = 0; b < len; b++) begin
            d = {$urandom, $urandom};
            if (b == 0) d[55:48] = route;
            src_q[port].push_back({(b == len - 1) ? 1'b1 : 1'b0, d});
            gap_q[port].push_back((b == 0) ? 0 : int'($urandom_range(gap_max, 0)));
        end
    endtask

    task automatic run(int max_cyc, int target);
        int gap_left [4];
        int in_cnt;
        int out_cnt;
        int cyc;
        logic prev_stall;
        logic [64:0] prev_word;
        in_cnt = 0; out_cnt = 0; cyc = 0; prev_stall = 1'b0; prev_word = '0;
        first_acc_cyc = -1; first_out_cyc = -1; max_occ = 0; hold_err = 0; multi_rdy_err = 0;
        ov_trace.delete(); rdy_trace.delete(); out_cyc.delete();
        for (int p = 0; p < 4; p++) gap_left[p] = (gap_q[p].size() > 0) ? gap_q[p][0] : 0;
        while (got_q.size() < target && cyc < max_cyc) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                if (src_q[p].size() > 0 && gap_left[p] == 0) begin
                    i_tvalid[p] = 1'b1;
                    {i_tlast[p], i_tdata[p]} = src_q[p][0];
                end else begin
                    i_tvalid[p] = 1'b0;
                    i_tlast[p]  = 1'b0;
                    i_tdata[p]  = '0;
                end
            end
            if (ordy_pat.size() > 0) o_tready = ordy_pat.pop_front();
            else o_tready = ($urandom_range(99, 0) >= bp_pct);
            #4;
            if ($countones(i_tready) > 1) multi_rdy_err++;
            if (prev_stall && (!o_tvalid || {o_tlast, o_tdata} !== prev_word)) hold_err++;
            if (in_cnt - out_cnt > max_occ) max_occ = in_cnt - out_cnt;
            ov_trace.push_back(o_tvalid);
            rdy_trace.push_back(i_tready);
            if (o_tvalid && first_out_cyc < 0) first_out_cyc = cyc;
            for (int p = 0; p < 4; p++) begin
                if (i_tvalid[p] && i_tready[p]) begin
                    void'(src_q[p].pop_front());
                    void'(gap_q[p].pop_front());
                    in_cnt++;
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    gap_left[p] = (gap_q[p].size() > 0) ? gap_q[p][0] : 0;
                end else if (gap_left[p] > 0 && src_q[p].size() > 0) begin
                    gap_left[p]--;
                end
            end
            if (o_tvalid && o_tready) begin
                got_q.push_back({o_tlast, o_tdata});
                out_cyc.push_back(cyc);
                out_cnt++;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_word  = {o_tlast, o_tdata};
            cyc++;
        end
        @(negedge clk);
        i_tvalid = '0;
        o_tready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_tvalid = 4'hF;
        i_tlast = '0;
        o_tready = 1'b1;
        @(negedge clk);
        #4;
        rst_rdy = i_tready;
        rst_ov  = o_tvalid;
        @(negedge clk);
        reset = 1'b0;
        i_tvalid = '0;
        model_rr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if (rst_rdy !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_tready got %b exp 0000", rst_rdy);
        end
        compared++;
        if (rst_ov !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_o_tvalid got %b exp 0", rst_ov);
        end
        #4;
        compared++;
        if (o_tvalid !== 1'b0 || i_tready !== 4'b0000) begin
            mismatched++;
            $display("FAIL post_reset_idle got ov=%b rdy=%b exp ov=0 rdy=0000", o_tvalid, i_tready);
        end
    endtask

    task automatic test_single_port();
        logic [63:0] d2, d3;
        do_reset();
        clear_all();
        bp_pct = 0;
        d2 = {$urandom, $urandom};
        d3 = {$urandom, $urandom};
        src_q[2].push_back({1'b0, 64'h0005_0000_4000_1000});
        src_q[2].push_back({1'b0, d2});
        src_q[2].push_back({1'b1, d3});
        for (int b = 0; b < 3; b++) gap_q[2].push_back(0);
        exp_q.push_back({1'b0, 64'h0016_0000_4000_1000});
        exp_q.push_back({1'b0, d2});
        exp_q.push_back({1'b1, d3});
        model_rr = 3;
        run(50, 3);
        compared++;
        if (got_q.size() !== 3) begin
            mismatched++;
            $display("FAIL single_count got %0d exp 3", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 3; k++) begin
            compared++;
            if (got_q[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL single_beat%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        compared++;
        if (first_out_cyc !== first_acc_cyc + 1) begin
            mismatched++;
            $display("FAIL single_latency got %0d exp %0d", first_out_cyc, first_acc_cyc + 1);
        end
    endtask

    task automatic test_contention();
        do_reset();
        clear_all();
        bp_pct = 0;
        for (int p = 0; p < 4; p++) add_pkt(p, 2, 0, 8'($urandom));
        build_expected();
        run(100, 8);
        compared++;
        if (got_q.size() !== 8) begin
            mismatched++;
            $display("FAIL contention_count got %0d exp 8", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            compared++;
            if (got_q[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL contention_beat%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        for (int k = 0; k < 4 && 2 * k < got_q.size(); k++) begin
            compared++;
            if (got_q[2 * k][49:48] !== 2'(k)) begin
                mismatched++;
                $display("FAIL contention_port%0d got %0d exp %0d", k, got_q[2 * k][49:48], k);
            end
        end
        if (out_cyc.size() == 8) begin
            compared++;
            if (out_cyc[7] - out_cyc[0] !== 7) begin
                mismatched++;
                $display("FAIL contention_throughput got %0d cycles exp 7", out_cyc[7] - out_cyc[0]);
            end
        end
    endtask

    task automatic test_lock_stall();
        do_reset();
        clear_all();
        bp_pct = 0;
        add_pkt(1, 3, 0, 8'($urandom));
        gap_q[1][1] = 3;
        add_pkt(0, 2, 0, 8'($urandom));
        gap_q[0][0] = 1;
        for (int b = 0; b < 3; b++) exp_q.push_back(xform(src_q[1][b], 1, b == 0));
        for (int b = 0; b < 2; b++) exp_q.push_back(xform(src_q[0][b], 0, b == 0));
        model_rr = 1;
        run(100, 5);
        compared++;
        if (got_q.size() !== 5) begin
            mismatched++;
            $display("FAIL stall_count got %0d exp 5", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 5; k++) begin
            compared++;
            if (got_q[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL stall_beat%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        if (rdy_trace.size() > 3) begin
            for (int c = 1; c <= 3; c++) begin
                compared++;
                if (rdy_trace[c][0] !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_i0_tready cycle %0d got %b exp 0", c, rdy_trace[c][0]);
                end
            end
            compared++;
            if (ov_trace[3] !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_o_tvalid got %b exp 0", ov_trace[3]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_all();
        bp_pct = 0;
        add_pkt(0, 4, 0, 8'($urandom));
        build_expected();
        ordy_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run(100, 4);
        compared++;
        if (got_q.size() !== 4) begin
            mismatched++;
            $display("FAIL bp_count got %0d exp 4", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            compared++;
            if (got_q[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL bp_beat%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        compared++;
        if (max_occ > 2 || hold_err !== 0) begin
            mismatched++;
            $display("FAIL bp_hold got occ=%0d hold_err=%0d exp occ<=2 hold_err=0", max_occ, hold_err);
        end
        if (out_cyc.size() > 0) begin
            compared++;
            if (out_cyc[0] !== 6) begin
                mismatched++;
                $display("FAIL bp_first_out got %0d exp 6", out_cyc[0]);
            end
        end
    endtask

    task automatic test_single_beat();
        int exp_port [8];
        clear_all();
        bp_pct = 0;
        for (int i = 0; i < 4; i++) begin
            add_pkt(3, 1, 0, 8'($urandom));
            add_pkt(0, 1, 0, 8'($urandom));
        end
`ifdef I_MERGE4_FIXED_PRIORITY_EN
        exp_port = '{0, 0, 0, 0, 3, 3, 3, 3};
`else
        exp_port = '{3, 0, 3, 0, 3, 0, 3, 0};
`endif
        build_expected();
        run(100, 8);
        compared++;
        if (got_q.size() !== 8) begin
            mismatched++;
            $display("FAIL sbeat_count got %0d exp 8", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 8; k++) begin
            compared++;
            if (got_q[k] !== exp_q[k] || got_q[k][49:48] !== 2'(exp_port[k])) begin
                mismatched++;
                $display("FAIL sbeat_grant%0d got %h exp %h port %0d", k, got_q[k], exp_q[k], exp_port[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            clear_all();
            bp_pct = 30;
            for (int p = 0; p < 4; p++)
                for (int n = $urandom_range(3, 1); n > 0; n--)
                    add_pkt(p, $urandom_range(4, 1), 2, 8'($urandom));
            build_expected();
            run(2000, exp_q.size());
            compared++;
            if (got_q.size() !== exp_q.size()) begin
                mismatched++;
                $display("FAIL rand%0d_count got %0d exp %0d", it, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                compared++;
                if (got_q[k] !== exp_q[k]) begin
                    mismatched++;
                    $display("FAIL rand%0d_beat%0d got %h exp %h", it, k, got_q[k], exp_q[k]);
                end
            end
            compared++;
            if (hold_err !== 0 || max_occ > 2 || multi_rdy_err !== 0) begin
                mismatched++;
                $display("FAIL rand%0d_protocol got hold=%0d occ=%0d multi=%0d exp 0/<=2/0",
                         it, hold_err, max_occ, multi_rdy_err);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_all();
        bp_pct = 0;
        add_pkt(2, 4, 0, 8'($urandom));
        run(2, 100);
        do_reset();
        compared++;
        if (rst_ov !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_o_tvalid got %b exp 0", rst_ov);
        end
        clear_all();
        add_pkt(3, 2, 0, 8'($urandom));
        add_pkt(0, 2, 0, 8'($urandom));
        build_expected();
        run(100, 4);
        compared++;
        if (got_q.size() !== 4) begin
            mismatched++;
            $display("FAIL midreset_count got %0d exp 4", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            compared++;
            if (got_q[k] !== exp_q[k]) begin
                mismatched++;
                $display("FAIL midreset_beat%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        if (got_q.size() > 0) begin
            compared++;
            if (got_q[0][49:48] !== 2'd0) begin
                mismatched++;
                $display("FAIL midreset_first_port got %0d exp 0", got_q[0][49:48]);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        model_rr   = 0;
        bp_pct     = 0;
        reset      = 1'b1;
        i_tvalid   = '0;
        i_tlast    = '0;
        o_tready   = 1'b1;
        for (int p = 0; p < 4; p++) i_tdata[p] = '0;
        test_reset();
        test_single_port();
        test_contention();
        test_lock_stall();
        test_backpressure();
        test_single_beat();
        test_random();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
